// File: rtl/prv_trap_pkg.sv
// Shared types and cause codes for the machine-mode trap sequencer.
// Vectored mtvec mode is enabled in the top when PRV_VECTORED_TVEC_EN is defined.
package prv_trap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StCommit,
    StRedirect
  } trap_state_t;

  typedef enum logic [1:0] {
    TvecDirect   = 2'b00,
    TvecVectored = 2'b01
  } tvec_mode_t;

  localparam int unsigned INSN_MISALIGN  = 0;
  localparam int unsigned INSN_FAULT     = 1;
  localparam int unsigned ILLEGAL_INSN   = 2;
  localparam int unsigned BREAKPOINT     = 3;
  localparam int unsigned LOAD_MISALIGN  = 4;
  localparam int unsigned LOAD_FAULT     = 5;
  localparam int unsigned STORE_MISALIGN = 6;
  localparam int unsigned STORE_FAULT    = 7;
  localparam int unsigned ECALL_M        = 11;
  localparam int unsigned RMGMT          = 24;
  localparam int unsigned M_SOFT_INT     = 3;
  localparam int unsigned M_TIMER_INT    = 7;
  localparam int unsigned M_EXT_INT      = 11;

endpackage

// File: rtl/prv_trap_prio_enc.sv
// Combinational priority encoder: picks the winning exception, else the winning
// enabled interrupt, and reports whether mtval should carry the faulting address.
module prv_trap_prio_enc
  import prv_trap_pkg::*;
#(
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               i_fault_insn,
  input  logic               i_mal_insn,
  input  logic               i_illegal_insn,
  input  logic               i_breakpoint,
  input  logic               i_env_m,
  input  logic               i_ex_rmgmt,
  input  logic               i_mal_s,
  input  logic               i_mal_l,
  input  logic               i_fault_s,
  input  logic               i_fault_l,
  input  logic               i_ext_en,
  input  logic               i_soft_en,
  input  logic               i_timer_en,
  output logic               o_valid,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_cause_int,
  output logic               o_use_badaddr
);

  always_comb begin
    o_valid       = 1'b1;
    o_cause       = '0;
    o_cause_int   = 1'b0;
    o_use_badaddr = 1'b0;
    if (i_fault_insn) begin
      o_cause       = CAUSE_W'(INSN_FAULT);
      o_use_badaddr = 1'b1;
    end else if (i_mal_insn) begin
      o_cause       = CAUSE_W'(INSN_MISALIGN);
      o_use_badaddr = 1'b1;
    end else if (i_illegal_insn) begin
      o_cause = CAUSE_W'(ILLEGAL_INSN);
    end else if (i_breakpoint) begin
      o_cause = CAUSE_W'(BREAKPOINT);
    end else if (i_env_m) begin
      o_cause = CAUSE_W'(ECALL_M);
    end else if (i_ex_rmgmt) begin
      o_cause = CAUSE_W'(RMGMT);
    end else if (i_mal_s) begin
      o_cause       = CAUSE_W'(STORE_MISALIGN);
      o_use_badaddr = 1'b1;
    end else if (i_mal_l) begin
      o_cause       = CAUSE_W'(LOAD_MISALIGN);
      o_use_badaddr = 1'b1;
    end else if (i_fault_s) begin
      o_cause       = CAUSE_W'(STORE_FAULT);
      o_use_badaddr = 1'b1;
    end else if (i_fault_l) begin
      o_cause       = CAUSE_W'(LOAD_FAULT);
      o_use_badaddr = 1'b1;
    end else if (i_ext_en) begin
      o_cause     = CAUSE_W'(M_EXT_INT);
      o_cause_int = 1'b1;
    end else if (i_soft_en) begin
      o_cause     = CAUSE_W'(M_SOFT_INT);
      o_cause_int = 1'b1;
    end else if (i_timer_en) begin
      o_cause     = CAUSE_W'(M_TIMER_INT);
      o_cause_int = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Trap entry / mret sequencer between the hazard unit and the machine CSR file.
// Define PRV_VECTORED_TVEC_EN to honour vectored mtvec mode for interrupts.
module prv_trap_sequencer
  import prv_trap_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               fault_insn,
  input  logic               mal_insn,
  input  logic               illegal_insn,
  input  logic               breakpoint,
  input  logic               env_m,
  input  logic               mal_s,
  input  logic               mal_l,
  input  logic               fault_s,
  input  logic               fault_l,
  input  logic               ex_rmgmt,
  input  logic               timer_int,
  input  logic               soft_int,
  input  logic               ext_int,
  input  logic               mie_g,
  input  logic               mtie,
  input  logic               msie,
  input  logic               meie,
  input  logic               pipe_clear,
  input  logic               ret,
  input  logic [XLEN-1:0]    epc,
  input  logic [XLEN-1:0]    badaddr,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_r,
  output logic               insert_pc,
  output logic [XLEN-1:0]    priv_pc,
  output logic               intr,
  output logic               csr_trap_we,
  output logic               csr_ret_we,
  output logic [CAUSE_W-1:0] cause,
  output logic               cause_int,
  output logic [XLEN-1:0]    tval,
  output logic               busy
);

  trap_state_t        r_state, w_state_d;
  logic               r_ret, w_ret_d;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_cause_int;
  logic [XLEN-1:0]    r_epc;
  logic [XLEN-1:0]    r_tval;
  logic               w_load;

  logic               w_valid;
  logic [CAUSE_W-1:0] w_cause;
  logic               w_cause_int;
  logic               w_use_badaddr;
  logic [XLEN-1:0]    w_tvec_base;
  logic [XLEN-1:0]    w_trap_pc;
  logic               w_unused;

  prv_trap_prio_enc #(
    .CAUSE_W(CAUSE_W)
  ) u_prio_enc (
    .i_fault_insn  (fault_insn),
    .i_mal_insn    (mal_insn),
    .i_illegal_insn(illegal_insn),
    .i_breakpoint  (breakpoint),
    .i_env_m       (env_m),
    .i_ex_rmgmt    (ex_rmgmt),
    .i_mal_s       (mal_s),
    .i_mal_l       (mal_l),
    .i_fault_s     (fault_s),
    .i_fault_l     (fault_l),
    .i_ext_en      (ext_int & meie & mie_g),
    .i_soft_en     (soft_int & msie & mie_g),
    .i_timer_en    (timer_int & mtie & mie_g),
    .o_valid       (w_valid),
    .o_cause       (w_cause),
    .o_cause_int   (w_cause_int),
    .o_use_badaddr (w_use_badaddr)
  );

  assign w_tvec_base = {mtvec[XLEN-1:2], 2'b00};

`ifdef PRV_VECTORED_TVEC_EN
  assign w_trap_pc = (tvec_mode_t'(mtvec[1:0]) == TvecVectored && r_cause_int) ?
                     w_tvec_base + (XLEN'(r_cause) << 2) : w_tvec_base;
  // The CSR file takes mepc from its own epc tap; the latched copy has no reader here.
  assign w_unused  = ^r_epc;
`else
  assign w_trap_pc = w_tvec_base;
  assign w_unused  = ^{r_epc, mtvec[1:0]};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_ret       <= 1'b0;
      r_cause     <= '0;
      r_cause_int <= 1'b0;
      r_epc       <= '0;
      r_tval      <= '0;
    end else begin
      r_state <= w_state_d;
      r_ret   <= w_ret_d;
      if (w_load) begin
        r_cause     <= w_cause;
        r_cause_int <= w_cause_int;
        r_epc       <= epc;
        r_tval      <= w_use_badaddr ? badaddr : '0;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_ret_d     = r_ret;
    w_load      = 1'b0;
    csr_trap_we = 1'b0;
    csr_ret_we  = 1'b0;
    insert_pc   = 1'b0;
    priv_pc     = '0;
    unique case (r_state)
      StIdle: begin
        // A pending trap swallows a simultaneous mret.
        if (w_valid) begin
          w_state_d = StDrain;
          w_ret_d   = 1'b0;
          w_load    = 1'b1;
        end else if (ret) begin
          w_state_d = StDrain;
          w_ret_d   = 1'b1;
        end
      end
      StDrain: begin
        if (pipe_clear) w_state_d = StCommit;
      end
      StCommit: begin
        csr_trap_we = ~r_ret;
        csr_ret_we  = r_ret;
        w_state_d   = StRedirect;
      end
      StRedirect: begin
        insert_pc = 1'b1;
        priv_pc   = r_ret ? mepc_r : w_trap_pc;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign busy      = (r_state != StIdle);
  assign intr      = busy;
  assign cause     = r_cause;
  assign cause_int = r_cause_int;
  assign tval      = r_tval;

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Randomised bench for prv_trap_sequencer against a transaction-level model of the
// trap/return timeline; directed cases cover priority, vectoring, masking and reset abort.
module tb_prv_trap_sequencer;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 5;

  logic CLK = 1'b0;
  logic RST;
  logic fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
  logic mal_s, mal_l, fault_s, fault_l, ex_rmgmt;
  logic timer_int, soft_int, ext_int, mie_g, mtie, msie, meie;
  logic pipe_clear, ret;
  logic [XLEN-1:0] epc, badaddr, mtvec, mepc_r;
  logic insert_pc, intr, csr_trap_we, csr_ret_we, cause_int, busy;
  logic [XLEN-1:0] priv_pc, tval;
  logic [CAUSE_W-1:0] cause;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  prv_trap_sequencer #(
    .XLEN   (XLEN),
    .CAUSE_W(CAUSE_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .fault_insn  (fault_insn),
    .mal_insn    (mal_insn),
    .illegal_insn(illegal_insn),
    .breakpoint  (breakpoint),
    .env_m       (env_m),
    .mal_s       (mal_s),
    .mal_l       (mal_l),
    .fault_s     (fault_s),
    .fault_l     (fault_l),
    .ex_rmgmt    (ex_rmgmt),
    .timer_int   (timer_int),
    .soft_int    (soft_int),
    .ext_int     (ext_int),
    .mie_g       (mie_g),
    .mtie        (mtie),
    .msie        (msie),
    .meie        (meie),
    .pipe_clear  (pipe_clear),
    .ret         (ret),
    .epc         (epc),
    .badaddr     (badaddr),
    .mtvec       (mtvec),
    .mepc_r      (mepc_r),
    .insert_pc   (insert_pc),
    .priv_pc     (priv_pc),
    .intr        (intr),
    .csr_trap_we (csr_trap_we),
    .csr_ret_we  (csr_ret_we),
    .cause       (cause),
    .cause_int   (cause_int),
    .tval        (tval),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_events();
    {fault_insn, mal_insn, illegal_insn, breakpoint, env_m} = '0;
    {mal_s, mal_l, fault_s, fault_l, ex_rmgmt} = '0;
    {timer_int, soft_int, ext_int, mie_g, mtie, msie, meie, ret} = '0;
  endtask

  task automatic rand_events();
    fault_insn   = ($urandom_range(0, 7) == 0);
    mal_insn     = ($urandom_range(0, 7) == 0);
    illegal_insn = ($urandom_range(0, 7) == 0);
    breakpoint   = ($urandom_range(0, 7) == 0);
    env_m        = ($urandom_range(0, 7) == 0);
    ex_rmgmt     = ($urandom_range(0, 7) == 0);
    mal_s        = ($urandom_range(0, 7) == 0);
    mal_l        = ($urandom_range(0, 7) == 0);
    fault_s      = ($urandom_range(0, 7) == 0);
    fault_l      = ($urandom_range(0, 7) == 0);
    timer_int    = ($urandom_range(0, 1) == 1);
    soft_int     = ($urandom_range(0, 1) == 1);
    ext_int      = ($urandom_range(0, 1) == 1);
    mtie         = ($urandom_range(0, 1) == 1);
    msie         = ($urandom_range(0, 1) == 1);
    meie         = ($urandom_range(0, 1) == 1);
    mie_g        = ($urandom_range(0, 3) != 0);
    ret          = ($urandom_range(0, 1) == 1);
    epc          = $urandom;
    badaddr      = $urandom;
  endtask

  // kind: 0 = nothing taken, 1 = trap, 2 = mret.
  function automatic void model(output int kind, output int code, output bit is_int,
                                output logic [31:0] tv);
    bit [9:0] ex;
    int codes [10];
    bit useb [10];
    codes = '{1, 0, 2, 3, 11, 24, 6, 4, 7, 5};
    useb  = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    ex = {fault_l, fault_s, mal_l, mal_s, ex_rmgmt, env_m, breakpoint, illegal_insn,
          mal_insn, fault_insn};
    kind = 0; code = 0; is_int = 0; tv = 32'h0;
    for (int i = 0; i < 10; i++) begin
      if (ex[i] && kind == 0) begin
        kind = 1;
        code = codes[i];
        tv   = useb[i] ? badaddr : 32'h0;
      end
    end
    if (kind == 0 && mie_g) begin
      if (ext_int && meie) begin kind = 1; code = 11; is_int = 1; end
      else if (soft_int && msie) begin kind = 1; code = 3; is_int = 1; end
      else if (timer_int && mtie) begin kind = 1; code = 7; is_int = 1; end
    end
    if (kind == 0 && ret) kind = 2;
  endfunction

  function automatic logic [31:0] trap_pc(input logic [31:0] tvec, input int code,
                                          input bit is_int);
    logic [31:0] base;
    base = tvec & 32'hFFFF_FFFC;
`ifdef PRV_VECTORED_TVEC_EN
    if (tvec[1:0] == 2'b01 && is_int) return base + 32'(code * 4);
`endif
    return base;
  endfunction

  // Caller has set the stimulus for cycle 0 (DUT idle). drain_lo = cycles pipe_clear stays low.
  task automatic run_txn(input int drain_lo, input int idle_cycles);
    int kind, code;
    bit is_int;
    logic [31:0] tv, tpc;
    model(kind, code, is_int, tv);
    tpc = trap_pc(mtvec, code, is_int);
    @(negedge CLK);
    chk("idle_intr", 32'(intr), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    if (kind == 0) begin
      for (int c = 1; c <= idle_cycles; c++) begin
        @(posedge CLK); #1;
        epc     = $urandom;
        badaddr = $urandom;
        @(negedge CLK);
        chk("quiet_intr", 32'(intr), 32'd0);
        chk("quiet_trap_we", 32'(csr_trap_we), 32'd0);
        chk("quiet_insert", 32'(insert_pc), 32'd0);
      end
      return;
    end
    for (int c = 1; c <= 3 + drain_lo; c++) begin
      @(posedge CLK); #1;
      rand_events();  // raw inputs must be ignored while busy
      pipe_clear = (c > drain_lo + 1) ? ($urandom_range(0, 1) == 1) : (c > drain_lo);
      @(negedge CLK);
      chk("busy_intr", 32'(intr), 32'd1);
      chk("busy_busy", 32'(busy), 32'd1);
      chk("trap_we", 32'(csr_trap_we), 32'(c == 2 + drain_lo && kind == 1));
      chk("ret_we", 32'(csr_ret_we), 32'(c == 2 + drain_lo && kind == 2));
      chk("insert_pc", 32'(insert_pc), 32'(c == 3 + drain_lo));
      if (c == 2 + drain_lo && kind == 1) begin
        chk("cause", 32'(cause), 32'(code));
        chk("cause_int", 32'(cause_int), 32'(is_int));
        chk("tval", tval, tv);
      end
      if (c == 3 + drain_lo) chk("priv_pc", priv_pc, (kind == 1) ? tpc : mepc_r);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_insert"}, 32'(insert_pc), 32'd0);
    chk({tag, "_priv_pc"}, priv_pc, 32'd0);
    chk({tag, "_intr"}, 32'(intr), 32'd0);
    chk({tag, "_trap_we"}, 32'(csr_trap_we), 32'd0);
    chk({tag, "_ret_we"}, 32'(csr_ret_we), 32'd0);
    chk({tag, "_cause"}, 32'(cause), 32'd0);
    chk({tag, "_cause_int"}, 32'(cause_int), 32'd0);
    chk({tag, "_tval"}, tval, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    clear_events();
    pipe_clear = 1'b0;
    epc = '0; badaddr = '0; mtvec = '0; mepc_r = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");

    // Illegal instruction, drained pipe: trap_we at cycle 2, redirect at cycle 3.
    @(posedge CLK); #1;
    RST = 1'b0;
    illegal_insn = 1'b1; epc = 32'h200; mtvec = 32'h8000_0000; pipe_clear = 1'b1;
    run_txn(0, 0);

    @(posedge CLK); #1;
    clear_events();
    mal_l = 1'b1; fault_s = 1'b1; badaddr = 32'h1003;
    run_txn(1, 0);

    @(posedge CLK); #1;
    clear_events();
    ext_int = 1'b1; meie = 1'b1; mie_g = 1'b1; mtvec = 32'h101;
    run_txn(0, 0);

    @(posedge CLK); #1;
    clear_events();
    timer_int = 1'b1; mtie = 1'b1; mie_g = 1'b0;
    run_txn(0, 10);

    @(posedge CLK); #1;
    clear_events();
    ret = 1'b1; mepc_r = 32'h4000;
    run_txn(5, 0);

    // Reset in DRAIN aborts the trap with no CSR write.
    @(posedge CLK); #1;
    clear_events();
    illegal_insn = 1'b1; badaddr = 32'hDEAD_BEEF; pipe_clear = 1'b0;
    @(posedge CLK); #1;
    clear_events();
    @(negedge CLK);
    chk("abort_drain_intr", 32'(intr), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1; pipe_clear = 1'b1;
    @(negedge CLK);
    chk("abort_trap_we", 32'(csr_trap_we), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("abort");
    repeat (6) begin
      @(negedge CLK);
      chk("abort_quiet_trap_we", 32'(csr_trap_we), 32'd0);
      chk("abort_quiet_intr", 32'(intr), 32'd0);
    end

    repeat (150) begin
      @(posedge CLK); #1;
      rand_events();
      mtvec      = $urandom;
      mepc_r     = $urandom;
      pipe_clear = ($urandom_range(0, 1) == 1);
      run_txn($urandom_range(0, 4), 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prv_trap_sequencer.md
Name: prv_trap_sequencer

Overview:
- Controller that sequences trap entry and trap return between the pipeline hazard unit and the machine-mode CSR file.
- Prioritises pending exceptions and interrupts, waits for the pipeline to drain, and commits mcause/mepc/mtval.
- Drives the redirect (insert_pc, priv_pc, intr) back to the hazard unit.
- Sits inside the priv block, between the exception-signal inputs and the CSR register storage.

Parameters:
- XLEN, 32, datapath and CSR width.
- CAUSE_W, 5, width of the cause code field committed to mcause.

Ports:
- CLK  input  1  core clock
- RST  input  1  synchronous, active-high reset
- fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_s, mal_l, fault_s, fault_l  input  1 each  exception flags from hazard unit
- ex_rmgmt  input  1  RISC-MGMT extension exception
- timer_int, soft_int, ext_int  input  1 each  raw interrupt pending
- mie_g  input  1  mstatus.MIE
- mtie, msie, meie  input  1 each  per-source enables
- pipe_clear  input  1  pipeline drained, no instruction in flight
- ret  input  1  mret committing
- epc  input  XLEN  PC of faulting/next instruction
- badaddr  input  XLEN  faulting address
- mtvec  input  XLEN  trap vector; bits[1:0] are the mode
- mepc_r  input  XLEN  current mepc
- insert_pc  output  1  one-cycle redirect strobe
- priv_pc  output  XLEN  redirect target
- intr  output  1  trap in progress (to hazard, stalls fetch)
- csr_trap_we  output  1  one-cycle write of mcause/mepc/mtval, with MIE->MPIE and MIE=0
- csr_ret_we  output  1  one-cycle mret commit: MIE<-MPIE, MPIE=1
- cause  output  CAUSE_W  cause code
- cause_int  output  1  mcause interrupt bit
- tval  output  XLEN  value for mtval
- busy  output  1  FSM not IDLE

Behaviour:
- Reset: every output 0; FSM in IDLE; latched cause/epc/tval 0. RST mid-sequence aborts the sequence with no CSR write.
- Exception priority, highest first (cause code in brackets): fault_insn(1), mal_insn(0), illegal_insn(2), breakpoint(3), env_m(11), ex_rmgmt(24), mal_s(6), mal_l(4), fault_s(7), fault_l(5).
- tval:
  - badaddr for causes 0, 1, 4, 5, 6, 7.
  - 0 for causes 2, 3, 11, 24.
- Interrupt enable: an interrupt is enabled when raw & per-source enable & mie_g.
- Interrupt priority: ext(11) > soft(3) > timer(7); tval = 0; cause_int = 1.
- An exception pending in the same cycle as an enabled interrupt wins. The interrupt stays pending and is re-evaluated after the return.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - Any exception or enabled interrupt: latch cause, cause_int, epc, tval; go to DRAIN; assert intr.
  - Else if ret: go to DRAIN with a return-pending flag.
  - If trap and ret are both pending, the trap wins and ret is dropped.
- DRAIN: hold intr=1; stay until pipe_clear=1, then go to COMMIT. Raw inputs are ignored while not IDLE; the latched values are used.
- COMMIT: one cycle.
  - Trap: csr_trap_we=1.
  - Return: csr_ret_we=1.
  - Always go to REDIRECT.
- REDIRECT: one cycle; insert_pc=1; go to IDLE; intr deasserts on the next cycle.
  - Trap: priv_pc = {mtvec[XLEN-1:2], 2'b00}.
  - Return: priv_pc = mepc_r, sampled in this cycle.
- Latency: with pipe_clear already high, detection to insert_pc is 3 cycles (IDLE → DRAIN → COMMIT → REDIRECT).
- Back-to-back: a new event is accepted in the first IDLE cycle after REDIRECT.
- busy = (state != IDLE).

Optional Feature:
- Macro: PRV_VECTORED_TVEC_EN.
- Defined: when mtvec[1:0]==2'b01 and cause_int=1, priv_pc = base + 4*cause (base = mtvec with bits[1:0] cleared; XLEN add, wrap ignored). Exceptions always go to base. Mode 2'b1x is treated as direct.
- Undefined: mode bits ignored; always direct.

Decomposition:
- prv_trap_pkg holds:
  - trap_state_t enum (IDLE, DRAIN, COMMIT, REDIRECT);
  - cause code localparams (INSN_MISALIGN=0 … M_EXT_INT=11, RMGMT=24);
  - tvec_mode_t.
- One sub-module, prv_trap_prio_enc: purely combinational priority encoder producing {valid, cause, cause_int, use_badaddr}. The FSM stays in the top module.

Test Plan:
- illegal_insn=1, epc=0x200, mtvec=0x8000_0000, pipe_clear=1 → csr_trap_we at cycle 2 with cause=2, tval=0; insert_pc at cycle 3 with priv_pc=0x8000_0000.
- mal_l=1 and fault_s=1 together, badaddr=0x1003 → cause=6? No: mal_s is absent, so priority yields mal_l: cause=4, tval=0x1003.
- ext_int=1, meie=1, mie_g=1, PRV_VECTORED_TVEC_EN defined, mtvec=0x100|1 → cause_int=1, cause=11, priv_pc=0x12C. With the macro undefined → priv_pc=0x100.
- timer_int=1, mtie=1, mie_g=0 → no trap; intr stays 0 for 10 cycles.
- ret=1, mepc_r=0x4000, pipe_clear held low 5 cycles → intr high throughout DRAIN; csr_ret_we one cycle after pipe_clear rises; insert_pc with priv_pc=0x4000.
- Trap in DRAIN, RST asserted for 1 cycle → all outputs 0 next cycle; no csr_trap_we ever pulses.
